dac_slew_ctrl: RTL and testbench

//  Per-channel setpoint slew limiter sitting directly upstream of the AD9783 controller in the clkD domain.

---
 rtl/dac_slew_ctrl.sv | 159 +++++++++++++++
 tb/tb_dac_slew_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_slew_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dac_slew_ctrl                                              |
// | Description : Two-channel DAC setpoint slew limiter with cmd-bus regs.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module dac_slew_ctrl #(
  parameter logic signed [15:0] CODE_MIN = 16'sh8000,
  parameter logic signed [15:0] CODE_MAX = 16'sh7FFF,
  parameter logic        [15:0] STEP_RST = 16'd1,
  parameter logic        [15:0] RATE_RST = 16'd0
) (
  input  logic               clkD,
  input  logic               rst_in,
  input  logic               cmd_trig_in,
  input  logic        [15:0] cmd_addr_in,
  input  logic        [15:0] cmd_data_in,
  output logic        [15:0] cmd_data_out,
  output logic signed [15:0] DAC0_out,
  output logic signed [15:0] DAC1_out,
  output logic        [1:0]  busy_out,
  output logic               tick_out
);

  localparam logic signed [17:0] c_max18 = {{2{CODE_MAX[15]}}, CODE_MAX};
  localparam logic signed [17:0] c_min18 = {{2{CODE_MIN[15]}}, CODE_MIN};

  logic        w_hit22, w_wr, w_rd, w_tick;
  logic [7:0]  w_off;
  logic [1:0]  w_wr_tgt, w_wr_step, w_busy;
  logic signed [15:0] w_wdata_sat;
  logic [15:0] w_rdata;
  logic [1:0][15:0] w_out, w_tgt, w_step;

  logic [15:0] r_rate, r_cnt, r_dout;
  logic [2:0]  r_ctrl;
  logic        r_tick;

  assign w_hit22   = cmd_trig_in && (cmd_addr_in[15:8] == 8'h22);
  assign w_off     = cmd_addr_in[7:0];
  assign w_wr      = w_hit22 && !cmd_addr_in[7];
  assign w_rd      = w_hit22 && cmd_addr_in[7];
  assign w_wr_tgt  = {w_wr && (w_off == 8'h01), w_wr && (w_off == 8'h00)};
  assign w_wr_step = {w_wr && (w_off == 8'h03), w_wr && (w_off == 8'h02)};
  assign w_tick    = (r_cnt == r_rate);

  always_comb begin
    w_wdata_sat = $signed(cmd_data_in);
    if ($signed(cmd_data_in) > CODE_MAX)      w_wdata_sat = CODE_MAX;
    else if ($signed(cmd_data_in) < CODE_MIN) w_wdata_sat = CODE_MIN;
  end

  // Prescaler, rate/ctrl registers and the registered tick strobe
  always_ff @(posedge clkD or posedge rst_in) begin
    if (rst_in) begin
      r_rate <= RATE_RST;
      r_cnt  <= '0;
      r_ctrl <= 3'b000;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_tick;
      if (w_wr && (w_off == 8'h04)) begin
        r_rate <= cmd_data_in;
        r_cnt  <= '0;
      end else if (w_tick) begin
        r_cnt  <= '0;
      end else begin
        r_cnt  <= r_cnt + 16'd1;
      end
      if (w_wr && (w_off == 8'h05)) r_ctrl <= cmd_data_in[2:0];
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    typedef enum logic [1:0] {S_HOLD = 2'd0, S_UP = 2'd1, S_DN = 2'd2} state_t;
    state_t             r_state, w_state_nxt;
    logic signed [15:0] r_tgt, r_out, w_tgt_nxt, w_out_nxt, w_sat;
    logic        [15:0] r_step;
    logic signed [16:0] w_diff;
    logic        [16:0] w_mag;
    logic signed [17:0] w_out18, w_step18, w_sum;

    always_ff @(posedge clkD or posedge rst_in) begin
      if (rst_in) begin
        r_state <= S_HOLD;
        r_tgt   <= '0;
        r_out   <= '0;
        r_step  <= STEP_RST;
      end else begin
        r_state <= w_state_nxt;
        r_tgt   <= w_tgt_nxt;
        r_out   <= w_out_nxt;
        if (w_wr_step[gi]) r_step <= cmd_data_in;
      end
    end

    always_comb begin
      w_tgt_nxt   = r_tgt;
      w_out_nxt   = r_out;
      w_state_nxt = r_state;
      w_diff   = {r_tgt[15], r_tgt} - {r_out[15], r_out};
      w_mag    = w_diff[16] ? (17'd0 - w_diff) : w_diff;
      w_out18  = {{2{r_out[15]}}, r_out};
      w_step18 = {2'b00, r_step};
      w_sum    = (r_state == S_DN) ? (w_out18 - w_step18) : (w_out18 + w_step18);
      if (w_sum > c_max18)      w_sat = CODE_MAX;
      else if (w_sum < c_min18) w_sat = CODE_MIN;
      else                      w_sat = w_sum[15:0];

      if (w_tick && r_ctrl[gi] && (r_state != S_HOLD)) begin
        if (w_mag <= {1'b0, r_step}) w_out_nxt = r_tgt;
        else                         w_out_nxt = w_sat;
      end
      // A jump load takes priority over the slew step of the same cycle
      if (w_wr_tgt[gi]) begin
        w_tgt_nxt = w_wdata_sat;
        if (r_ctrl[2]) w_out_nxt = w_wdata_sat;
      end

      if (w_out_nxt == w_tgt_nxt)     w_state_nxt = S_HOLD;
      else if (w_out_nxt < w_tgt_nxt) w_state_nxt = S_UP;
      else                            w_state_nxt = S_DN;
    end

    assign w_out[gi]  = r_out;
    assign w_tgt[gi]  = r_tgt;
    assign w_step[gi] = r_step;
    assign w_busy[gi] = (r_out != r_tgt);
  end

  always_comb begin
    w_rdata = 16'h0000;
    case (w_off)
      8'h80: w_rdata = w_tgt[0];
      8'h81: w_rdata = w_tgt[1];
      8'h82: w_rdata = w_step[0];
      8'h83: w_rdata = w_step[1];
      8'h84: w_rdata = r_rate;
      8'h85: w_rdata = {13'd0, r_ctrl};
      8'h86: w_rdata = w_out[0];
      8'h87: w_rdata = w_out[1];
      8'h88: w_rdata = {14'd0, w_busy};
      default: w_rdata = 16'h0000;
    endcase
  end

  always_ff @(posedge clkD or posedge rst_in) begin
    if (rst_in)    r_dout <= '0;
    else if (w_rd) r_dout <= w_rdata;
  end

  assign cmd_data_out = r_dout;
  assign DAC0_out     = w_out[0];
  assign DAC1_out     = w_out[1];
  assign busy_out     = w_busy;
  assign tick_out     = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_dac_slew_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_dac_slew_ctrl                                           |
// | Description : Scoreboard bench for dac_slew_ctrl with behavioural model. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_dac_slew_ctrl;

  logic        clkD = 1'b0;
  logic        rst_in = 1'b1;
  logic        cmd_trig_in = 1'b0;
  logic [15:0] cmd_addr_in = '0;
  logic [15:0] cmd_data_in = '0;
  logic [15:0] cmd_data_out, DAC0_out, DAC1_out;
  logic [1:0]  busy_out;
  logic        tick_out;

  dac_slew_ctrl dut (
    .clkD         (clkD),
    .rst_in       (rst_in),
    .cmd_trig_in  (cmd_trig_in),
    .cmd_addr_in  (cmd_addr_in),
    .cmd_data_in  (cmd_data_in),
    .cmd_data_out (cmd_data_out),
    .DAC0_out     (DAC0_out),
    .DAC1_out     (DAC1_out),
    .busy_out     (busy_out),
    .tick_out     (tick_out)
  );

  always #5 clkD = ~clkD;

  typedef struct {
    logic [15:0] d0, d1, dout;
    logic [1:0]  busy;
    logic        tick;
  } exp_t;
  exp_t q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: plain integers
  int       m_tgt[2], m_out[2], m_step[2];
  int       m_rate, m_cnt;
  logic [2:0]  m_ctrl;
  logic [15:0] m_dout;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int clampc(input int v);
    if (v < -32768) return -32768;
    if (v > 32767)  return 32767;
    return v;
  endfunction

  function automatic logic [1:0] m_busy();
    return {m_out[1] != m_tgt[1], m_out[0] != m_tgt[0]};
  endfunction

  function automatic logic [15:0] m_read(input logic [7:0] off);
    case (off)
      8'h80: return 16'(m_tgt[0]);
      8'h81: return 16'(m_tgt[1]);
      8'h82: return 16'(m_step[0]);
      8'h83: return 16'(m_step[1]);
      8'h84: return 16'(m_rate);
      8'h85: return {13'd0, m_ctrl};
      8'h86: return 16'(m_out[0]);
      8'h87: return 16'(m_out[1]);
      8'h88: return {14'd0, m_busy()};
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_tgt[c] = 0; m_out[c] = 0; m_step[c] = 1;
    end
    m_rate = 0; m_cnt = 0; m_ctrl = 3'b000; m_dout = 16'h0000;
  endtask

  task automatic push_exp(input logic tk);
    exp_t e;
    e.d0 = 16'(m_out[0]); e.d1 = 16'(m_out[1]); e.dout = m_dout;
    e.busy = m_busy(); e.tick = tk;
    q.push_back(e);
  endtask

  // Apply inputs for the coming clock edge and predict the state after it
  task automatic drive(input logic trig, input logic [15:0] addr, input logic [15:0] data);
    bit tk, is22;
    int nout[2];
    int d, mag, ch;
    cmd_trig_in = trig; cmd_addr_in = addr; cmd_data_in = data;
    tk = (m_cnt == m_rate);
    for (int c = 0; c < 2; c++) begin
      nout[c] = m_out[c];
      if (tk && m_ctrl[c] && (m_out[c] != m_tgt[c])) begin
        d   = m_tgt[c] - m_out[c];
        mag = (d < 0) ? -d : d;
        if (mag <= m_step[c]) nout[c] = m_tgt[c];
        else nout[c] = clampc((d > 0) ? m_out[c] + m_step[c] : m_out[c] - m_step[c]);
      end
    end
    is22 = trig && (addr[15:8] == 8'h22);
    if (is22 && addr[7]) m_dout = m_read(addr[7:0]);
    if (is22 && addr[7:0] == 8'h04) m_cnt = 0;
    else if (tk)                    m_cnt = 0;
    else                            m_cnt = m_cnt + 1;
    if (is22 && !addr[7]) begin
      ch = int'(addr[0]);
      case (addr[7:0])
        8'h00, 8'h01: begin
          m_tgt[ch] = clampc(int'($signed(data)));
          if (m_ctrl[2]) nout[ch] = m_tgt[ch];
        end
        8'h02, 8'h03: m_step[ch] = int'(data);
        8'h04: m_rate = int'(data);
        8'h05: m_ctrl = data[2:0];
        default: ;
      endcase
    end
    m_out[0] = nout[0]; m_out[1] = nout[1];
    push_exp(tk);
  endtask

  task automatic cycle(input logic trig, input logic [15:0] addr, input logic [15:0] data);
    @(negedge clkD); #1;
    drive(trig, addr, data);
  endtask

  task automatic wr(input logic [15:0] addr, input logic [15:0] data);
    cycle(1'b1, addr, data);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic do_reset();
    @(negedge clkD); #1;
    rst_in = 1'b1; cmd_trig_in = 1'b0; #1;
    chk("rst_async_dac0", DAC0_out, 16'h0000);
    chk("rst_async_dac1", DAC1_out, 16'h0000);
    model_reset();
    push_exp(1'b0);
    @(negedge clkD); #1;
    rst_in = 1'b0;
    drive(1'b0, 16'h0000, 16'h0000);
  endtask

  always @(negedge clkD) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("dac0", DAC0_out, e.d0);
      chk("dac1", DAC1_out, e.d1);
      chk("rdata", cmd_data_out, e.dout);
      chk("busy", {14'd0, busy_out}, {14'd0, e.busy});
      chk("tick", {15'd0, tick_out}, {15'd0, e.tick});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a, dat;
    int r;
    model_reset();
    do_reset();

    // Ramp 0 -> 100 in steps of 10 at full rate
    wr(16'h2204, 16'd0); wr(16'h2202, 16'd10); wr(16'h2205, 16'd3); wr(16'h2200, 16'd100);
    idle(14);
    chk("ramp_end_dac0", DAC0_out, 16'd100);
    chk("ramp_end_busy", {14'd0, busy_out}, 16'd0);

    // No overshoot toward -5 with step 4
    wr(16'h2205, 16'd4); wr(16'h2200, 16'd0); wr(16'h2205, 16'd3);
    wr(16'h2202, 16'd4); wr(16'h2200, 16'hFFFB);
    idle(6);
    chk("neg_end_dac0", DAC0_out, 16'hFFFB);

    // Huge step saturates to the target in one tick, rate 3
    wr(16'h2204, 16'd3); wr(16'h2203, 16'hFFFF); wr(16'h2201, 16'h7FFF);
    idle(12);
    chk("sat_dac1", DAC1_out, 16'h7FFF);

    // Jump load with channels disabled
    wr(16'h2205, 16'd4); wr(16'h2200, 16'd1234);
    idle(2);
    chk("jump_dac0", DAC0_out, 16'd1234);
    chk("jump_busy", {14'd0, busy_out}, 16'd0);

    // Target change coincident with a tick
    wr(16'h2204, 16'd0); wr(16'h2200, 16'd1000); wr(16'h2202, 16'd1000);
    wr(16'h2205, 16'd1); wr(16'h2200, 16'd2000); wr(16'h2200, 16'd4000);
    idle(5);
    chk("coinc_dac0", DAC0_out, 16'd4000);

    for (int i = 16'h80; i <= 16'h89; i++) begin
      cycle(1'b1, 16'h2200 | 16'(i), 16'h0000);
    end
    cycle(1'b1, 16'h1280, 16'h0000);

    // Reset mid-ramp, then step register reads back its reset value
    wr(16'h2205, 16'd3); wr(16'h2202, 16'd1); wr(16'h2200, 16'd30000);
    idle(5);
    do_reset();
    cycle(1'b1, 16'h2282, 16'h0000);
    idle(2);
    chk("post_rst_step0", cmd_data_out, 16'd1);

    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      if ($urandom_range(0, 9) < 3) begin
        r   = $urandom_range(0, 19);
        dat = 16'($urandom);
        if (r <= 5)       a = 16'h2200 + 16'(r);
        else if (r <= 14) a = 16'h2280 + 16'(r - 6);
        else if (r == 15) a = 16'h2289;
        else if (r == 16) a = 16'h2206;
        else if (r == 17) a = 16'h2300 + 16'($urandom_range(0, 255));
        else if (r == 18) a = 16'($urandom);
        else              a = 16'h22FF;
        if (a[15:8] == 8'h22 && r == 18) a = 16'h2390;
        if (a == 16'h2202 || a == 16'h2203) begin
          case ($urandom_range(0, 5))
            0: dat = 16'd0;
            1: dat = 16'hFFFF;
            default: dat = 16'($urandom_range(1, 3000));
          endcase
        end
        if (a == 16'h2204) dat = 16'($urandom_range(0, 3));
        if (a == 16'h2205) dat = {13'd0, ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3))};
        cycle(1'b1, a, dat);
      end else begin
        cycle(1'b0, 16'($urandom), 16'($urandom));
      end
    end

    @(negedge clkD); @(negedge clkD); #1;
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
